// File: rtl/sr_ff_pkg.sv
// rtl/sr_ff_pkg.sv - conflict-policy encodings and popcount helper shared by the SR flip-flop bank
package sr_ff_pkg;

  localparam int MODE_RST_DOM = 0;
  localparam int MODE_SET_DOM = 1;
  localparam int MODE_TOGGLE  = 2;
  localparam int MODE_HOLD    = 3;

  localparam int MAX_WIDTH = 64;
  localparam int PC_W      = 7;

  typedef struct packed {
    logic set_req;
    logic rst_req;
  } sr_req_t;

  function automatic logic [PC_W-1:0] popcount(input logic [MAX_WIDTH-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      n = n + PC_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// rtl/sr_ff_cell.sv - one SR channel: state bit, sticky conflict flag and rising-edge pulse
module sr_ff_cell
  import sr_ff_pkg::*;
#(
  parameter int   MODE    = MODE_RST_DOM,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic s,
  input  logic r,
  input  logic load,
  input  logic d,
  input  logic clr_conflict,
  output logic q,
  output logic conflict,
  output logic rise,
  output logic conflict_event
);

  logic    q_prev;
  logic    q_next;
  logic    both_q;
  sr_req_t req;

  assign req            = '{set_req: s, rst_req: r};
  assign conflict_event = en & s & r & ~load;

  // Resolution of s=r=1 is fixed at elaboration; only toggle/hold depend on state.
  always_comb begin
    case (MODE)
      MODE_SET_DOM: both_q = 1'b1;
      MODE_TOGGLE:  both_q = ~q;
      MODE_HOLD:    both_q = q;
      default:      both_q = 1'b0;
    endcase
  end

  always_comb begin
    q_next = q;
    if (load) begin
      q_next = d;
    end else if (en) begin
      case (req)
        2'b01:   q_next = 1'b0;
        2'b10:   q_next = 1'b1;
        2'b11:   q_next = both_q;
        default: q_next = q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q        <= RST_VAL;
      q_prev   <= RST_VAL;
      conflict <= 1'b0;
    end else begin
      q        <= q_next;
      q_prev   <= q;
      conflict <= conflict_event | (conflict & ~clr_conflict);
    end
  end

  assign rise = q & ~q_prev;

endmodule

// File: rtl/sr_ff_bank.sv
// rtl/sr_ff_bank.sv - bank of independent SR flip-flops with sticky conflict flags and a saturating conflict counter
module sr_ff_bank
  import sr_ff_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               MODE    = MODE_RST_DOM,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] clr_conflict,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] conflict_cnt,
  output logic [WIDTH-1:0] rise
);

  localparam int SUM_W = CNT_W + 1;
  localparam int CMP_W = (SUM_W > PC_W) ? SUM_W : PC_W;
  localparam logic [SUM_W-1:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  if (MODE < MODE_RST_DOM || MODE > MODE_HOLD) begin : g_bad_mode
    $error("sr_ff_bank: MODE %0d is not a legal conflict policy", MODE);
  end

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("sr_ff_bank: WIDTH %0d is out of range", WIDTH);
  end

  logic [WIDTH-1:0] events;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sr_ff_cell #(
      .MODE    (MODE),
      .RST_VAL (RST_VAL[i])
    ) u_cell (
      .clk            (clk),
      .rst            (rst),
      .en             (en[i]),
      .s              (s[i]),
      .r              (r[i]),
      .load           (load),
      .d              (d[i]),
      .clr_conflict   (clr_conflict[i]),
      .q              (q[i]),
      .conflict       (conflict[i]),
      .rise           (rise[i]),
      .conflict_event (events[i])
    );
  end

  assign qn = ~q;

  logic [PC_W-1:0]  pc;
  logic [SUM_W-1:0] pc_sat;
  logic [SUM_W-1:0] base;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] cnt_next;

  // Both addends are clipped to CNT_MAX, so the CNT_W+1 bit sum cannot overflow.
  always_comb begin
    pc       = popcount(MAX_WIDTH'(events));
    pc_sat   = (CMP_W'(pc) > CMP_W'(CNT_MAX)) ? CNT_MAX : SUM_W'(pc);
    base     = cnt_clr ? '0 : {1'b0, conflict_cnt};
    sum      = base + pc_sat;
    cnt_next = (sum > CNT_MAX) ? CNT_MAX : sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else begin
      conflict_cnt <= cnt_next[CNT_W-1:0];
    end
  end

endmodule
